// File: rtl/counter_seq_if.sv
// rtl/counter_seq_if.sv - command handshake interface for the counter sequencer
//
// Purpose: groups the command valid/ready handshake and its payload.
// Signals:
//   CMD_VALID  command offered (master -> slave)
//   CMD_READY  sequencer can accept a command (slave -> master)
//   CMD_MODO   counter mode for the command
//   CMD_D      load value presented on the counter D input
//   CMD_LEN    number of enabled cycles, 0 = no-op
interface counter_seq_if #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 4
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_MODO;
    logic [CNT_W-1:0] CMD_D;
    logic [LEN_W-1:0] CMD_LEN;

    modport master (
        output CMD_VALID,
        output CMD_MODO,
        output CMD_D,
        output CMD_LEN,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_MODO,
        input  CMD_D,
        input  CMD_LEN,
        output CMD_READY
    );
endinterface

// File: rtl/counter_seq.sv
// rtl/counter_seq.sv - command sequencer driving a 4-bit mode counter
//
// Purpose: accepts one command at a time, drives the counter ENABLE/MODO/D
// pins for CMD_LEN cycles, then reports the final counter value and the
// number of RCO-high samples and pulses DONE.
// Ports:
//   clk      system clock, rising edge
//   RESET    asynchronous active-low reset
//   cmd      command handshake (slave side)
//   CNT_Q    counter Q output
//   CNT_RCO  counter ripple-carry output
//   ENABLE   counter ENABLE
//   MODO     counter MODO
//   D        counter D
//   BUSY     command in progress
//   DONE     one-cycle completion pulse
//   Q_LAST   counter Q captured at completion
//   RCO_CNT  RCO-high samples of the last command, saturating
module counter_seq #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             RESET,
    counter_seq_if.slave     cmd,
    input  logic [CNT_W-1:0] CNT_Q,
    input  logic             CNT_RCO,
    output logic             ENABLE,
    output logic [1:0]       MODO,
    output logic [CNT_W-1:0] D,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] Q_LAST,
    output logic [LEN_W-1:0] RCO_CNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] remaining, remaining_n;
    logic [LEN_W-1:0] acc, acc_n;
    // Set once the counter has seen at least one enabled edge; RCO is only
    // meaningful (and only sampled) from the cycle after that edge.
    logic             gate, gate_n;

    logic             enable_n;
    logic [1:0]       modo_n;
    logic [CNT_W-1:0] d_n;
    logic             busy_n;
    logic             done_n;
    logic [CNT_W-1:0] q_last_n;
    logic [LEN_W-1:0] rco_cnt_n;

    logic [LEN_W-1:0] acc_inc;
    logic [LEN_W-1:0] acc_sampled;

    assign cmd.CMD_READY = (state == IDLE) && RESET;

    // Saturating increment: hold at all-ones rather than wrapping to zero.
    assign acc_inc     = (&acc) ? acc : acc + LEN_W'(1);
    assign acc_sampled = (gate && CNT_RCO) ? acc_inc : acc;

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        acc_n       = acc;
        gate_n      = gate;
        enable_n    = ENABLE;
        modo_n      = MODO;
        d_n         = D;
        busy_n      = BUSY;
        done_n      = 1'b0;
        q_last_n    = Q_LAST;
        rco_cnt_n   = RCO_CNT;

        case (state)
            IDLE: begin
                if (cmd.CMD_VALID) begin
                    modo_n      = cmd.CMD_MODO;
                    d_n         = cmd.CMD_D;
                    remaining_n = cmd.CMD_LEN;
                    acc_n       = '0;
                    gate_n      = 1'b0;
                    busy_n      = 1'b1;
                    if (cmd.CMD_LEN != '0) begin
                        enable_n = 1'b1;
                        state_n  = RUN;
                    end else begin
                        enable_n = 1'b0;
                        state_n  = SETTLE;
                    end
                end
            end
            RUN: begin
                gate_n      = 1'b1;
                acc_n       = acc_sampled;
                remaining_n = remaining - LEN_W'(1);
                // remaining never goes below 1 while in RUN, so no underflow.
                if (remaining == LEN_W'(1)) begin
                    enable_n = 1'b0;
                    state_n  = SETTLE;
                end
            end
            SETTLE: begin
                // Counter output now reflects the last enabled edge.
                q_last_n  = CNT_Q;
                acc_n     = acc_sampled;
                rco_cnt_n = acc_sampled;
                done_n    = 1'b1;
                busy_n    = 1'b0;
                state_n   = FIN;
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            gate      <= 1'b0;
            ENABLE    <= 1'b0;
            MODO      <= 2'b00;
            D         <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            Q_LAST    <= '0;
            RCO_CNT   <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            acc       <= acc_n;
            gate      <= gate_n;
            ENABLE    <= enable_n;
            MODO      <= modo_n;
            D         <= d_n;
            BUSY      <= busy_n;
            DONE      <= done_n;
            Q_LAST    <= q_last_n;
            RCO_CNT   <= rco_cnt_n;
        end
    end

endmodule
